// File: rtl/pwm_pkg.sv
// Shared types for the PWM generator/capture pair.
// Counter vectors are declared as logic [W-1:0] in each module so both sides share one width.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_PRIME = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } pwm_cap_state_e;

    localparam int PWM_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, plus one extra flop for
// single-cycle rise/fall strobes in the clk domain.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM line in clk
// cycles, and flags a line that stays at one level long enough to saturate the counter.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int W           = PWM_CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_in,
    output logic [W-1:0] high_cnt,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         stuck,
    output logic         stuck_level
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic pwm_s, rise, fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .level (pwm_s),
        .rise  (rise),
        .fall  (fall)
    );

    pwm_cap_state_e state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   high_q, high_d;
    logic [W-1:0]   period_q, period_d;
    logic           valid_q, valid_d;
    logic           stuck_q, stuck_d;
    logic           level_q, level_d;
    logic           sat;
    logic           sat_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARM;
            cnt_q    <= CNT_ONE;
            hi_q     <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            level_q  <= level_d;
        end
    end

    assign sat = (cnt_q == CNT_MAX);

    // The counter is not reloaded on HIGH->LOW so that it spans the whole
    // rise-to-rise period; a terminating edge always takes priority over saturation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = sat ? cnt_q : cnt_q + CNT_ONE;
        hi_d     = hi_q;
        high_d   = high_q;
        period_d = period_q;
        valid_d  = 1'b0;
        sat_evt  = 1'b0;
        unique case (state_q)
            ST_ARM: begin
                if (fall) begin
                    state_d = ST_PRIME;
                    cnt_d   = CNT_ONE;
                end else if (sat) begin
                    sat_evt = 1'b1;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRIME: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ONE;
                end else if (sat) begin
                    sat_evt = 1'b1;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                    hi_d    = cnt_q;
                end else if (sat) begin
                    sat_evt = 1'b1;
                    state_d = ST_ARM;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d  = ST_HIGH;
                    cnt_d    = CNT_ONE;
                    period_d = cnt_q;
                    high_d   = hi_q;
                    valid_d  = 1'b1;
                end else if (sat) begin
                    sat_evt = 1'b1;
                    state_d = ST_PRIME;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = ST_ARM;
                cnt_d   = CNT_ONE;
            end
        endcase
    end

    always_comb begin
        stuck_d = stuck_q;
        level_d = level_q;
        if (rise || fall) begin
            stuck_d = 1'b0;
        end
        if (sat_evt) begin
            stuck_d = 1'b1;
            level_d = pwm_s;
        end
    end

    assign high_cnt    = high_q;
    assign period      = period_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = level_q;

endmodule
